// File: rtl/spi_register_responder_pkg.sv
// Shared types and sizing for the SPI register responder and its register bank.
package spi_register_responder_pkg;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 16;
    localparam int NUM_REGS   = 1 << ADDR_W;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    localparam logic [BIT_CNT_W-1:0] CNT_START    = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] CNT_CMD_LAST = BIT_CNT_W'(FRAME_BITS - DATA_W);

    localparam logic [DATA_W-1:0] DEVID_DEFAULT = 8'hE5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        HOLD
    } resp_state_t;

endpackage

// File: rtl/spi_reg_bank.sv
// 64x8 register bank: one write port, two asynchronous read ports, address 0 reads DEVID.
module spi_reg_bank
    import spi_register_responder_pkg::*;
#(
    parameter logic [DATA_W-1:0] DEVID = DEVID_DEFAULT
) (
    input  logic              spi_clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [0:NUM_REGS-1];

    // Entry 0 is never written; it is shadowed by DEVID on both read ports.
    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? DEVID : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? DEVID : mem[raddr_b];

endmodule

// File: rtl/spi_register_responder.sv
// SPI (mode 3) slave giving 16-bit framed read/write access to a 64x8 register bank,
// with a host-side port sharing the same bank.
//
// state | meaning
// IDLE  | waiting for a chip-select falling edge
// CMD   | shifting in R/nW, reserved bit and 6-bit address
// WDATA | shifting in 8 write-data bits, commit after the last one
// RDATA | shifting the latched register out on SPI_SDO
// HOLD  | frame complete, ignoring edges until chip select rises
module spi_register_responder
    import spi_register_responder_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] DEVID       = DEVID_DEFAULT
) (
    input  logic              spi_clk,
    input  logic              reset,
    input  logic              SPI_CSN,
    input  logic              SPI_CLK,
    input  logic              SPI_SDI,
    output logic              SPI_SDO,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic              reg_wr_en,
    input  logic [DATA_W-1:0] reg_wr_data,
    output logic [DATA_W-1:0] reg_rd_data,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int                  SETTLE_W     = $clog2(SYNC_STAGES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_START = SETTLE_W'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] csn_sync, clk_sync, sdi_sync;
    logic                   csn_s, clk_s, sdi_s;
    logic                   csn_d, clk_d;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic                   armed;
    logic                   csn_fall, csn_rise, clk_rise, clk_fall;

    resp_state_t            state, next_state;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_W-2:0]      cmd_sr;
    logic [DATA_W-2:0]      wdata_sr;
    logic [DATA_W-1:0]      tx_sr;
    logic                   sdo_r;

    logic                   cnt_load, cnt_dec;
    logic                   shift_cmd, shift_wdata, latch_tx, shift_tx, commit;
    logic                   rnw_next;
    logic [ADDR_W-1:0]      addr_next, cmd_addr;
    logic [DATA_W-1:0]      wdata_next;
    logic                   spi_we;
    logic                   bank_we;
    logic [ADDR_W-1:0]      bank_waddr;
    logic [DATA_W-1:0]      bank_wdata;
    logic [DATA_W-1:0]      host_rd, tx_load;

    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            csn_sync <= '1;
            clk_sync <= '1;
            sdi_sync <= '1;
        end else begin
            csn_sync[0] <= SPI_CSN;
            clk_sync[0] <= SPI_CLK;
            sdi_sync[0] <= SPI_SDI;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                csn_sync[i] <= csn_sync[i-1];
                clk_sync[i] <= clk_sync[i-1];
                sdi_sync[i] <= sdi_sync[i-1];
            end
        end
    end

    assign csn_s = csn_sync[SYNC_STAGES-1];
    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign sdi_s = sdi_sync[SYNC_STAGES-1];

    // The synchronizers reset to CSN=1, so a CSN held low across reset would look like
    // a fresh falling edge; frames are only accepted once CSN has been seen high after reset.
    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            csn_d      <= 1'b1;
            clk_d      <= 1'b1;
            settle_cnt <= SETTLE_START;
            armed      <= 1'b0;
        end else begin
            csn_d <= csn_s;
            clk_d <= clk_s;
            if (settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end else if (csn_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign csn_fall = armed & csn_d & ~csn_s;
    assign csn_rise = ~csn_d & csn_s;
    assign clk_rise = ~clk_d & clk_s;
    assign clk_fall = clk_d & ~clk_s;

    assign rnw_next   = cmd_sr[DATA_W-2];
    assign addr_next  = {cmd_sr[ADDR_W-2:0], sdi_s};
    assign cmd_addr   = cmd_sr[ADDR_W-1:0];
    assign wdata_next = {wdata_sr, sdi_s};

    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        shift_cmd   = 1'b0;
        shift_wdata = 1'b0;
        latch_tx    = 1'b0;
        shift_tx    = 1'b0;
        commit      = 1'b0;
        if (csn_rise) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (csn_fall) begin
                        next_state = CMD;
                        cnt_load   = 1'b1;
                    end
                end
                CMD: begin
                    if (clk_rise) begin
                        shift_cmd = 1'b1;
                        cnt_dec   = 1'b1;
                        if (bit_cnt == CNT_CMD_LAST) begin
                            if (rnw_next) begin
                                next_state = RDATA;
                                latch_tx   = 1'b1;
                            end else begin
                                next_state = WDATA;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (clk_rise) begin
                        shift_wdata = 1'b1;
                        cnt_dec     = 1'b1;
                        if (bit_cnt == '0) begin
                            commit     = 1'b1;
                            next_state = HOLD;
                        end
                    end
                end
                RDATA: begin
                    shift_tx = clk_fall;
                    if (clk_rise) begin
                        cnt_dec = 1'b1;
                        if (bit_cnt == '0) begin
                            next_state = HOLD;
                        end
                    end
                end
                HOLD: begin
                    next_state = HOLD;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    assign spi_we = commit & (cmd_addr != '0);

    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            wdata_sr    <= '0;
            tx_sr       <= '1;
            sdo_r       <= 1'b1;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            reg_rd_data <= '0;
        end else begin
            if (cnt_load) begin
                bit_cnt <= CNT_START;
            end else if (cnt_dec) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (shift_cmd) begin
                cmd_sr <= {cmd_sr[DATA_W-3:0], sdi_s};
            end
            if (shift_wdata) begin
                wdata_sr <= {wdata_sr[DATA_W-3:0], sdi_s};
            end
            // SDO holds high until the first falling edge in RDATA presents TX[7].
            if (latch_tx) begin
                tx_sr <= tx_load;
                sdo_r <= 1'b1;
            end else if (shift_tx) begin
                sdo_r <= tx_sr[DATA_W-1];
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b1};
            end
            wr_strobe <= spi_we;
            if (spi_we) begin
                wr_addr <= cmd_addr;
                wr_data <= wdata_next;
            end
            reg_rd_data <= host_rd;
        end
    end

    assign SPI_SDO = (state == RDATA) ? sdo_r : 1'b1;

    // Single write port: an SPI commit takes it, a host write in the same cycle is dropped.
    assign bank_we    = spi_we | reg_wr_en;
    assign bank_waddr = spi_we ? cmd_addr   : reg_addr;
    assign bank_wdata = spi_we ? wdata_next : reg_wr_data;

    spi_reg_bank #(
        .DEVID (DEVID)
    ) u_reg_bank (
        .spi_clk (spi_clk),
        .reset   (reset),
        .we      (bank_we),
        .waddr   (bank_waddr),
        .wdata   (bank_wdata),
        .raddr_a (reg_addr),
        .rdata_a (host_rd),
        .raddr_b (addr_next),
        .rdata_b (tx_load)
    );

endmodule

// File: doc/spi_register_responder.md
SPI_REGISTER_RESPONDER -- requirements
Module: spi_register_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each SPI input.
REQ-002 SHALL have parameter DEVID, default 8'hE5, read-only value of register 0x00.
REQ-003 SHALL have ports: spi_clk  in  1  system clock, at least 4x the SPI_CLK rate.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 SPI_CSN  in  1  chip select, active low.
REQ-006 SPI_CLK  in  1  serial clock, idles high (CPOL=1, CPHA=1).
REQ-007 SPI_SDI  in  1  serial data from the initiator, MSB first.
REQ-008 SPI_SDO  out  1  serial data to the initiator, MSB first.
REQ-009 reg_addr  in  6  host-side register address.
REQ-010 reg_wr_en  in  1  host-side write strobe.
REQ-011 reg_wr_data  in  8  host-side write data.
REQ-012 reg_rd_data  out  8  host-side read data, one-cycle latency.
REQ-013 wr_strobe  out  1  one-cycle pulse when an SPI write commits.
REQ-014 wr_addr  out  6  address of the last committed SPI write.
REQ-015 wr_data  out  8  data of the last committed SPI write.

Function
REQ-016 SPI_CSN, SPI_CLK and SPI_SDI SHALL each pass through SYNC_STAGES flops clocked by spi_clk; all logic SHALL use only the synchronized copies.
REQ-017 A rising edge SHALL be a synchronized SPI_CLK transition 0->1; a falling edge SHALL be 1->0.
REQ-018 A frame SHALL be 16 bits: bit15 = R/nW (1 = read), bit14 ignored, bits13:8 = address, bits7:0 = write data or read slot.
REQ-019 FSM states SHALL be IDLE, CMD, WDATA, RDATA and HOLD.
REQ-020 IDLE->CMD on synchronized CSN falling; the bit counter loads 15.
REQ-021 CMD SHALL shift SDI in on each rising edge; after the 8th bit it goes to RDATA if R/nW=1, otherwise to WDATA.
REQ-022 On CMD->RDATA, the addressed register SHALL be latched into a TX shift register in the same cycle.
REQ-023 RDATA SHALL drive TX[7] on SPI_SDO after the first falling edge, and shift one bit per subsequent falling edge.
REQ-024 WDATA SHALL shift 8 bits on rising edges.
REQ-025 After the 8th WDATA bit, the write SHALL commit to the register file, pulse wr_strobe once, and update wr_addr and wr_data.
REQ-026 After 16 bits, the FSM SHALL enter HOLD; further edges SHALL be ignored until CSN rises.
REQ-027 CSN rising in any state SHALL return the FSM to IDLE on the next cycle; a partial write SHALL NOT commit.
REQ-028 SPI_SDO SHALL be 1 whenever the FSM is not in RDATA.
REQ-029 Register 0x00 SHALL read DEVID; writes to it, from SPI or the host port, SHALL be discarded without a wr_strobe.
REQ-030 When an SPI commit and reg_wr_en hit the same address in the same cycle, the SPI write SHALL win.
REQ-031 Host writes SHALL be visible to an SPI read latched in the following cycle or later.

Reset
REQ-032 Reset SHALL force the FSM to IDLE, clear the synchronizers to idle levels (CSN=1, CLK=1, SDI=1), and clear registers 0x01-0x3F to 0.
REQ-033 Reset SHALL drive SPI_SDO=1, wr_strobe=0, wr_addr=0, wr_data=0 and reg_rd_data=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame; the responder SHALL wait for a fresh CSN falling edge.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, ADDR_W=6, FRAME_BITS=16 and the DEVID default.
REQ-036 The register file SHALL be a sub-module, spi_reg_bank (64x8, one write port, two read ports, with address 0 hard-wired).

Verification
REQ-037 SPI write 0x12 <- 0xA5 -> wr_strobe pulses once; wr_addr=0x12, wr_data=0xA5; a host read of 0x12 returns 0xA5.
REQ-038 SPI read of 0x00 -> SDO carries 8'hE5 MSB first in the last 8 bit slots.
REQ-039 Host writes 0x3F <- 0x5A, then SPI read of 0x3F -> SDO returns 0x5A.
REQ-040 SPI write to 0x05 with CSN raised after 12 bits -> no wr_strobe; register 0x05 stays 0.
REQ-041 SPI write and host write to 0x07 in the same cycle (0x11 vs 0x22) -> register 0x07 = 0x11.
REQ-042 Reset pulsed mid-read, then a new read of 0x00 -> SDO=1 until RDATA; the new read returns 0xE5.
